// File: rtl/sobel_pkg.sv
// Shared widths and constants for the Sobel stream engine.
// Width helpers take the pixel width so every module derives the same sizes.
package sobel_pkg;

    // Rows only matter up to "two full lines seen", so the counter saturates.
    localparam int ROW_W = 2;
    localparam logic [ROW_W-1:0] ROW_FULL = 2'd2;

    // Signed gradient width: +/-4*(2^DATA_W-1) fits in DATA_W+3 bits.
    function automatic int grad_w(input int data_w);
        return data_w + 3;
    endfunction

    // Unsigned |Gx|+|Gy| width before saturation.
    function automatic int mag_w(input int data_w);
        return data_w + 4;
    endfunction

    // Largest value representable on the output pixel.
    function automatic int sat_max(input int data_w);
        return (1 << data_w) - 1;
    endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One line of pixel storage, combinational read, write on enable.
// Ports: clk, wr_en, addr (column), wr_data, rd_data (old value at addr).
module sobel_line_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 640
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read returns the pre-write value, so chained buffers shift a line.
    assign rd_data = mem[addr];

    // Storage is never reset; the row counter masks stale contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/sobel_stream_engine.sv
// Streaming 3x3 Sobel edge engine: raster pixels in, |Gx|+|Gy| out.
// Ports: clk, rst_n, in_* (valid/ready/data/sof), thresh, out_* (valid/ready/mag/edge/sof/eol).
module sobel_stream_engine
    import sobel_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] thresh,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_mag,
    output logic              out_edge,
    output logic              out_sof,
    output logic              out_eol
);

    localparam int CW = $clog2(IMG_W);
    localparam int GW = grad_w(DATA_W);
    localparam int MW = mag_w(DATA_W);
    localparam logic [MW-1:0] SAT = MW'(sat_max(DATA_W));
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);

    logic en;

    assign in_ready = !out_valid || out_ready;
    assign en = in_valid && in_ready;

    // Position of the pixel on in_data; in_sof restarts the frame.
    logic [CW-1:0]    col_q;
    logic [ROW_W-1:0] row_q;
    logic [CW-1:0]    col;
    logic [ROW_W-1:0] row;
    logic             emitted_q;
    logic             emitted;
    logic [DATA_W-1:0] thr_q;
    logic [DATA_W-1:0] thr_cur;
    logic             win_ok;

    assign col = in_sof ? '0 : col_q;
    assign row = in_sof ? '0 : row_q;
    assign emitted = in_sof ? 1'b0 : emitted_q;
    assign thr_cur = in_sof ? thresh : thr_q;
    assign win_ok = (row == ROW_FULL) && (col >= CW'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q     <= '0;
            row_q     <= '0;
            emitted_q <= 1'b0;
            thr_q     <= '0;
        end else if (en) begin
            if (col == LAST_COL) begin
                col_q <= '0;
                row_q <= (row == ROW_FULL) ? row : row + ROW_W'(1);
            end else begin
                col_q <= col + CW'(1);
                row_q <= row;
            end
            emitted_q <= emitted || win_ok;
            thr_q     <= thr_cur;
        end
    end

    // mid_px is line r-1, top_px is line r-2 at the current column.
    logic [DATA_W-1:0] mid_px;
    logic [DATA_W-1:0] top_px;

    sobel_line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W)
    ) u_lb_mid (
        .clk     (clk),
        .wr_en   (en),
        .addr    (col),
        .wr_data (in_data),
        .rd_data (mid_px)
    );

    sobel_line_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W)
    ) u_lb_top (
        .clk     (clk),
        .wr_en   (en),
        .addr    (col),
        .wr_data (mid_px),
        .rd_data (top_px)
    );

    // Stage 1: 3x3 window, win[row][col], row 0 = oldest line, col 2 = newest.
    logic [DATA_W-1:0] win [3][3];
    logic              v1, sof1, eol1;
    logic [DATA_W-1:0] thr1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win[i][j] <= '0;
                end
            end
            v1   <= 1'b0;
            sof1 <= 1'b0;
            eol1 <= 1'b0;
            thr1 <= '0;
        end else if (en) begin
            for (int i = 0; i < 3; i++) begin
                win[i][0] <= win[i][1];
                win[i][1] <= win[i][2];
            end
            win[0][2] <= top_px;
            win[1][2] <= mid_px;
            win[2][2] <= in_data;
            v1   <= win_ok;
            sof1 <= win_ok && !emitted;
            eol1 <= (col == LAST_COL);
            thr1 <= thr_cur;
        end
    end

    // Stage 2: signed gradients.
    function automatic logic signed [GW-1:0] wsum(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] c
    );
        return $signed(GW'(a) + (GW'(b) << 1) + GW'(c));
    endfunction

    logic signed [GW-1:0] gx_d, gy_d, gx_q, gy_q;
    logic                 v2, sof2, eol2;
    logic [DATA_W-1:0]    thr2;

    always_comb begin
        gy_d = wsum(win[0][0], win[0][1], win[0][2])
             - wsum(win[2][0], win[2][1], win[2][2]);
        gx_d = wsum(win[0][2], win[1][2], win[2][2])
             - wsum(win[0][0], win[1][0], win[2][0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx_q <= '0;
            gy_q <= '0;
            v2   <= 1'b0;
            sof2 <= 1'b0;
            eol2 <= 1'b0;
            thr2 <= '0;
        end else if (en) begin
            gx_q <= gx_d;
            gy_q <= gy_d;
            v2   <= v1;
            sof2 <= sof1;
            eol2 <= eol1;
            thr2 <= thr1;
        end
    end

    // Stage 3: magnitude, saturation, threshold.
    logic signed [GW-1:0] ax, ay;
    logic [MW-1:0]        mag;
    logic [DATA_W-1:0]    mag_sat;

    always_comb begin
        ax = gx_q[GW-1] ? -gx_q : gx_q;
        ay = gy_q[GW-1] ? -gy_q : gy_q;
        mag = MW'($unsigned(ax)) + MW'($unsigned(ay));
        mag_sat = (mag > SAT) ? SAT[DATA_W-1:0] : mag[DATA_W-1:0];
    end

    // A consumed result with no new input behind it must not repeat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_mag   <= '0;
            out_edge  <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
        end else if (en) begin
            out_valid <= v2;
            out_mag   <= mag_sat;
            out_edge  <= (mag_sat >= thr2);
            out_sof   <= sof2;
            out_eol   <= eol2;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_stream_engine.sv
// Scoreboard bench for sobel_stream_engine (IMG_W=5 and IMG_W=3 instances).
// Expected outputs are queued as window-completing pixels are driven.
module tb_sobel_stream_engine;

    logic clk;
    logic rst_n;

    logic       a_in_valid, a_in_ready, a_in_sof, a_out_valid, a_out_ready;
    logic       a_out_edge, a_out_sof, a_out_eol;
    logic [7:0] a_in_data, a_thresh, a_out_mag;
    logic       b_in_valid, b_in_ready, b_in_sof, b_out_valid, b_out_ready;
    logic       b_out_edge, b_out_sof, b_out_eol;
    logic [7:0] b_in_data, b_thresh, b_out_mag;

    sobel_stream_engine #(.DATA_W(8), .IMG_W(5)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_sof    (a_in_sof),
        .thresh    (a_thresh),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_mag   (a_out_mag),
        .out_edge  (a_out_edge),
        .out_sof   (a_out_sof),
        .out_eol   (a_out_eol)
    );

    sobel_stream_engine #(.DATA_W(8), .IMG_W(3)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_sof    (b_in_sof),
        .thresh    (b_thresh),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_mag   (b_out_mag),
        .out_edge  (b_out_edge),
        .out_sof   (b_out_sof),
        .out_eol   (b_out_eol)
    );

    int          asserts = 0;
    int          fails = 0;
    logic [10:0] qa[$];
    logic [10:0] qb[$];
    int          img [0:7][0:7];
    bit          rnd_rdy = 0;
    bit          gaps = 0;
    bit          stall_a = 0, stall_b = 0;
    logic [10:0] held_a = '0, held_b = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        asserts++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference Sobel on img, packed as {sof, eol, edge, mag}.
    function automatic logic [10:0] model(input int w, input int r,
                                          input int c, input int thr);
        int gx, gy, p, m;
        gx = 0;
        gy = 0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                p = img[r-2+i][c-2+j];
                gx += (j - 1) * ((i == 1) ? 2 : 1) * p;
                gy += (1 - i) * ((j == 1) ? 2 : 1) * p;
            end
        end
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (m > 255) m = 255;
        return {(r == 2 && c == 2), (c == w - 1), (m >= thr), 8'(m)};
    endfunction

    task automatic drive_px(input int s, input logic [7:0] d,
                            input logic sof, input logic [7:0] th);
        int n;
        logic rdy;
        n = 0;
        if (s == 0) begin
            a_in_valid = 1'b1; a_in_data = d; a_in_sof = sof; a_thresh = th;
        end else begin
            b_in_valid = 1'b1; b_in_data = d; b_in_sof = sof; b_thresh = th;
        end
        forever begin
            @(negedge clk);
            rdy = (s == 0) ? a_in_ready : b_in_ready;
            if (rdy) break;
            n++;
            if (n > 200) begin
                check("in_ready_timeout", 32'(rdy), 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        if (gaps && $urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int s, input int w, input int npix,
                              input int thr, input bit use_sof,
                              input bit push);
        for (int k = 0; k < npix; k++) begin
            int r, c;
            logic first;
            r = k / w;
            c = k % w;
            first = use_sof && (k == 0);
            if (push && r >= 2 && c >= 2) begin
                if (s == 0) qa.push_back(model(w, r, c, thr));
                else qb.push_back(model(w, r, c, thr));
            end
            drive_px(s, 8'(img[r][c]), first, first ? 8'(thr) : 8'hff);
        end
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                img[r][c] = $urandom_range(0, 255);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 1000) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_a", 32'(qa.size()), 32'd0);
        check("drain_b", 32'(qb.size()), 32'd0);
    endtask

    task automatic observe(input int s, input logic v, input logic rdy,
                           input logic [10:0] val);
        logic [10:0] e;
        bit          st;
        logic [10:0] hv;
        st = (s == 0) ? stall_a : stall_b;
        hv = (s == 0) ? held_a : held_b;
        if (st) check((s == 0) ? "hold_a" : "hold_b", 32'({v, val}),
                      32'({1'b1, hv}));
        if (v && rdy) begin
            if (s == 0 && qa.size() > 0) begin
                e = qa.pop_front();
                check("out_a", 32'(val), 32'(e));
            end else if (s == 1 && qb.size() > 0) begin
                e = qb.pop_front();
                check("out_b", 32'(val), 32'(e));
            end else begin
                check((s == 0) ? "extra_a" : "extra_b", 32'(v), 32'd0);
            end
        end
        if (s == 0) begin
            stall_a = v && !rdy;
            held_a = val;
        end else begin
            stall_b = v && !rdy;
            held_b = val;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_a = 0;
                stall_b = 0;
                qa.delete();
                qb.delete();
            end else begin
                observe(0, a_out_valid, a_out_ready,
                        {a_out_sof, a_out_eol, a_out_edge, a_out_mag});
                observe(1, b_out_valid, b_out_ready,
                        {b_out_sof, b_out_eol, b_out_edge, b_out_mag});
            end
        end
    end

    initial begin
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            a_out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            b_out_ready = 1'b1;
        end
    end

    initial begin
        rst_n = 1'b0;
        a_in_valid = 0; a_in_data = 0; a_in_sof = 0; a_thresh = 0;
        b_in_valid = 0; b_in_data = 0; b_in_sof = 0; b_thresh = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_a", 32'(a_out_valid), 32'd0);
        check("rst_mag_a", 32'(a_out_mag), 32'd0);
        check("rst_ready_a", 32'(a_in_ready), 32'd1);
        check("rst_valid_b", 32'(b_out_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 3x3 image: Gy=14, Gx=-6, mag 20, at thresh 20 then 21.
        img[0][0] = 9;  img[0][1] = 6; img[0][2] = 8;
        img[1][0] = 7;  img[1][1] = 7; img[1][2] = 7;
        img[2][0] = 10; img[2][1] = 0; img[2][2] = 5;
        qb.push_back({1'b1, 1'b1, 1'b1, 8'd20});
        send_frame(1, 3, 9, 20, 1, 0);
        qb.push_back({1'b1, 1'b1, 1'b0, 8'd20});
        send_frame(1, 3, 9, 21, 1, 0);
        send_frame(1, 3, 2, 0, 1, 0);

        // Flat frame: all zero magnitude.
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                img[r][c] = 50;
        send_frame(0, 5, 25, 10, 1, 1);

        // Step edge saturating at 255.
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                img[r][c] = (c < 2) ? 0 : 100;
        send_frame(0, 5, 25, 128, 1, 1);

        // Random frames under back-pressure and input gaps.
        rnd_rdy = 1;
        gaps = 1;
        for (int f = 0; f < 4; f++) begin
            fill_rand();
            send_frame(0, 5, 5 * $urandom_range(3, 6),
                       $urandom_range(0, 255), 1, 1);
        end

        // Frame cut short by a new in_sof.
        fill_rand();
        send_frame(0, 5, 14, $urandom_range(0, 255), 1, 1);
        fill_rand();
        send_frame(0, 5, 25, $urandom_range(0, 255), 1, 1);
        send_frame(0, 5, 2, 0, 1, 0);
        drain();

        // Reset mid-frame after 7 pixels.
        fill_rand();
        send_frame(0, 5, 7, 77, 1, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(a_out_valid), 32'd0);
        check("async_rst_ready", 32'(a_in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // No in_sof: position restarts and latched threshold is 0.
        fill_rand();
        send_frame(0, 5, 25, 0, 0, 1);
        send_frame(0, 5, 2, 0, 1, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end

endmodule

// File: doc/sobel_stream_engine.md
SOBEL_STREAM_ENGINE -- requirements
Module: sobel_stream_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, unsigned pixel width in bits.
REQ-002 SHALL have parameter IMG_W, default 640, pixels per input line, minimum 3.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1, input pixel valid.
REQ-006 SHALL have port in_ready, output, 1, engine accepts a pixel.
REQ-007 SHALL have port in_data, input, DATA_W, raster-order grey pixel.
REQ-008 SHALL have port in_sof, input, 1, marks the first pixel of a frame.
REQ-009 SHALL have port thresh, input, DATA_W, edge threshold; sampled on each accepted in_sof pixel.
REQ-010 SHALL have port out_valid, output, 1, output pixel valid.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts.
REQ-012 SHALL have port out_mag, output, DATA_W, saturated gradient magnitude.
REQ-013 SHALL have port out_edge, output, 1, out_mag >= latched thresh.
REQ-014 SHALL have ports out_sof and out_eol, output, 1 each, first pixel of frame and last pixel of line.

Function
REQ-015 SHALL accept a pixel when in_valid && in_ready; in_ready = !out_valid || out_ready; all stages advance only on that enable.
REQ-016 SHALL keep out_mag/out_edge/out_sof/out_eol stable while out_valid && !out_ready.
REQ-017 SHALL track column (0..IMG_W-1, wraps to 0 and increments row) and row counters; accepted in_sof forces the pixel to column 0, row 0 and discards any partial window.
REQ-018 SHALL store the two previous lines in two IMG_W-deep line buffers and form a 3x3 window (top = oldest line).
REQ-019 SHALL emit one output per window only when input row >= 2 and column >= 2; output frame is (rows-2) x (IMG_W-2); no border padding.
REQ-020 SHALL compute Gy = (t0 + 2*t1 + t2) - (b0 + 2*b1 + b2) and Gx = (r0 + 2*r1 + r2) - (l0 + 2*l1 + l2), signed DATA_W+3 bits, no overflow.
REQ-021 SHALL compute mag = |Gx| + |Gy| at DATA_W+4 bits unsigned; out_mag = min(mag, 2^DATA_W-1).
REQ-022 SHALL assert out_sof with the first output of a frame and out_eol with output column IMG_W-3.
REQ-023 SHALL have a latency of exactly 3 enabled cycles from acceptance of the window-completing pixel to out_valid.
REQ-024 SHALL not emit outputs whose window spans a frame boundary.

Reset
REQ-025 SHALL on rst_n low drive out_valid, out_mag, out_edge, out_sof, out_eol, internal valids, counters and the thresh latch to 0 immediately.
REQ-026 SHALL not reset line buffer storage; contents are masked by the row counter.
REQ-027 SHALL after rst_n release treat the next pixel as column 0, row 0 regardless of in_sof.

Structure
REQ-028 SHALL place gradient width (DATA_W+3), magnitude width and the saturation constant in a shared package sobel_pkg.
REQ-029 SHALL implement line storage as sub-module sobel_line_buffer (parameters DATA_W, DEPTH), instantiated twice.

Verification
REQ-030 SHALL cover: IMG_W=5, 5x5 frame of all 50 -> 9 outputs, mag 0, edge 0, out_sof on first, out_eol on every 3rd.
REQ-031 SHALL cover: IMG_W=3, rows {9,6,8},{7,7,7},{10,0,5}, thresh=20 -> one output, mag 20 (Gy=14, Gx=-6), edge 1, sof=eol=1; repeat with thresh=21 -> edge 0.
REQ-032 SHALL cover: IMG_W=5, DATA_W=8, columns 0-1 = 0, columns 2-4 = 100, 5 rows -> each output row 255,255,0 (saturation of 400).
REQ-033 SHALL cover: random frames with out_ready toggling 50% -> output sequence equals golden model, no loss/duplication, data stable during stall.
REQ-034 SHALL cover: rst_n low after 7 pixels -> out_valid 0 same cycle; next full frame matches golden model.
REQ-035 SHALL cover: in_sof reasserted mid-frame -> partial frame yields no further outputs, new frame outputs correct from its third row.
